// File: rtl/negation_checker_pkg.sv
// Shared definitions for the negation checker: verdict kind layout and the
// reference logical-negation helper.
package negation_pkg;

  localparam int OPERAND_W = 32;
  localparam int KIND_BIT  = 0;
  localparam int KIND_LOG  = 1;

  typedef logic [1:0] kind_t;

  // Logical negation widened to the operand width: only bit 0 may ever be set.
  function automatic logic [OPERAND_W-1:0] logical_neg(input logic [OPERAND_W-1:0] a);
    return {{(OPERAND_W-1){1'b0}}, (a == {OPERAND_W{1'b0}})};
  endfunction

endpackage

// File: rtl/negation_checker_if.sv
// Transaction input stream and verdict output stream of the negation checker.
interface negation_checker_if
  import negation_pkg::*;
#(
  parameter int W = OPERAND_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_c;
  logic         res_valid;
  logic         res_ready;
  logic         res_ok;
  kind_t        res_kind;

  modport master (
    output in_valid, in_a, in_b, in_c, res_ready,
    input  in_ready, res_valid, res_ok, res_kind
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, res_ready,
    output in_ready, res_valid, res_ok, res_kind
  );
endinterface

// File: rtl/negation_checker_sat_counter.sv
// Saturating event counter with synchronous reset and clear; never wraps.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Count register: clear wins over increment, increment stops at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {CW{1'b0}};
    end else if (clr) begin
      count <= {CW{1'b0}};
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end
endmodule

// File: rtl/negation_checker.sv
// Two-stage streaming checker for bitwise and logical negation claims, with
// saturating statistics and sticky capture of the first failing verdict.
module negation_checker
  import negation_pkg::*;
#(
  parameter int W  = OPERAND_W,
  parameter int CW = 16
) (
  input  logic               clk,
  input  logic               rst,
  negation_checker_if.slave  bus,
  input  logic               clear,
  output logic [CW-1:0]      cnt_total,
  output logic [CW-1:0]      cnt_bit_err,
  output logic [CW-1:0]      cnt_log_err,
  output logic               first_err_valid,
  output logic [W-1:0]       first_err_a,
  output kind_t              first_err_kind
);
  logic         s1_v_r;
  logic [W-1:0] s1_a_r;
  kind_t        s1_kind_r;
  logic         s2_v_r;
  logic [W-1:0] s2_a_r;
  kind_t        s2_kind_r;
  logic         s2_ok_r;

  logic         s2_adv_s;
  logic         s1_adv_s;
  logic         hs_s;
  kind_t        in_kind_s;

  // Flow control and the mismatch compare of the incoming transaction.
  always_comb begin
    in_kind_s           = 2'b00;
    s2_adv_s            = !s2_v_r || bus.res_ready;
    s1_adv_s            = !s1_v_r || s2_adv_s;
    hs_s                = s2_v_r && bus.res_ready;
    in_kind_s[KIND_BIT] = |(bus.in_b ^ ~bus.in_a);
    in_kind_s[KIND_LOG] = (bus.in_c != logical_neg(bus.in_a));
  end

  assign bus.in_ready  = s1_adv_s;
  assign bus.res_valid = s2_v_r;
  assign bus.res_ok    = s2_ok_r;
  assign bus.res_kind  = s2_kind_r;

  // Stage 1: capture operand and the two mismatch bits on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r    <= 1'b0;
      s1_a_r    <= {W{1'b0}};
      s1_kind_r <= 2'b00;
    end else if (s1_adv_s) begin
      s1_v_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a_r    <= bus.in_a;
        s1_kind_r <= in_kind_s;
      end
    end
  end

  // Stage 2: verdict register; data only moves when stage 1 holds a transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_r    <= 1'b0;
      s2_a_r    <= {W{1'b0}};
      s2_kind_r <= 2'b00;
      s2_ok_r   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        s2_a_r    <= s1_a_r;
        s2_kind_r <= s1_kind_r;
        s2_ok_r   <= (s1_kind_r == 2'b00);
      end
    end
  end

  // Sticky first failure; clear re-arms and suppresses a same-cycle capture.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      first_err_valid <= 1'b0;
      first_err_a     <= {W{1'b0}};
      first_err_kind  <= 2'b00;
    end else if (hs_s && !s2_ok_r && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_a     <= s2_a_r;
      first_err_kind  <= s2_kind_r;
    end
  end

  sat_counter #(.CW(CW)) u_cnt_total (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (hs_s),
    .count (cnt_total)
  );

  sat_counter #(.CW(CW)) u_cnt_bit (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (hs_s && s2_kind_r[KIND_BIT]),
    .count (cnt_bit_err)
  );

  sat_counter #(.CW(CW)) u_cnt_log (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (hs_s && s2_kind_r[KIND_LOG]),
    .count (cnt_log_err)
  );
endmodule

// File: tb/tb_negation_checker.sv
// Bench: two checkers (CW=16 and CW=2) fed identical streams, compared against
// a queue-based model of a 2-deep, 2-cycle-latency verdict pipeline.
module tb_negation_checker;
  import negation_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  always #5 clk = ~clk;

  negation_checker_if #(.W(32)) bus_a ();
  negation_checker_if #(.W(32)) bus_b ();

  logic [15:0] tot_a, bit_a, log_a;
  logic [1:0]  tot_b, bit_b, log_b;
  logic        fev_a, fev_b;
  logic [31:0] fa_a, fa_b;
  logic [1:0]  fk_a, fk_b;

  negation_checker #(.W(32), .CW(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .clear(clear),
    .cnt_total(tot_a), .cnt_bit_err(bit_a), .cnt_log_err(log_a),
    .first_err_valid(fev_a), .first_err_a(fa_a), .first_err_kind(fk_a)
  );

  negation_checker #(.W(32), .CW(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .clear(clear),
    .cnt_total(tot_b), .cnt_bit_err(bit_b), .cnt_log_err(log_b),
    .first_err_valid(fev_b), .first_err_a(fa_b), .first_err_kind(fk_b)
  );

  int errors = 0;
  int checks = 0;

  // Model: transactions in flight (oldest first), with edges seen since accept.
  logic [31:0] m_a[$];
  logic [1:0]  m_k[$];
  int          m_age[$];
  int unsigned m_tot, m_bit, m_log;
  logic        m_fev;
  logic [31:0] m_fa;
  logic [1:0]  m_fk;
  logic        m_after_rst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat(input int unsigned x, input int unsigned m);
    return (x > m) ? m : x;
  endfunction

  function automatic logic model_valid();
    return (m_a.size() > 0) && (m_age[0] >= 1);
  endfunction

  task automatic check_outputs();
    logic ev;
    ev = model_valid();
    chk("res_valid_a", bus_a.res_valid, ev);
    chk("res_valid_b", bus_b.res_valid, ev);
    if (ev) begin
      chk("res_ok_a", bus_a.res_ok, m_k[0] == 2'b00);
      chk("res_kind_a", bus_a.res_kind, m_k[0]);
      chk("res_kind_b", bus_b.res_kind, m_k[0]);
    end
    if (m_after_rst) begin
      chk("rst_res_ok", bus_a.res_ok, 1'b0);
      chk("rst_res_kind", bus_a.res_kind, 2'b00);
      m_after_rst = 1'b0;
    end
    chk("cnt_total_a", tot_a, sat(m_tot, 65535));
    chk("cnt_bit_a", bit_a, sat(m_bit, 65535));
    chk("cnt_log_a", log_a, sat(m_log, 65535));
    chk("cnt_total_b", tot_b, sat(m_tot, 3));
    chk("cnt_bit_b", bit_b, sat(m_bit, 3));
    chk("cnt_log_b", log_b, sat(m_log, 3));
    chk("first_err_valid_a", fev_a, m_fev);
    chk("first_err_valid_b", fev_b, m_fev);
    chk("first_err_a", fa_a, m_fev ? m_fa : 32'h0);
    chk("first_err_kind", fk_a, m_fev ? m_fk : 2'b00);
    chk("first_err_a_b", fa_b, m_fev ? m_fa : 32'h0);
  endtask

  // One clock cycle: drive, check in_ready, advance model on the edge, check outputs.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic rr, input logic clr, input logic r);
    logic ev, er, hs, acc;
    logic [1:0] k;
    bus_a.in_valid = v;  bus_b.in_valid = v;
    bus_a.in_a = a;      bus_b.in_a = a;
    bus_a.in_b = b;      bus_b.in_b = b;
    bus_a.in_c = c;      bus_b.in_c = c;
    bus_a.res_ready = rr; bus_b.res_ready = rr;
    clear = clr;
    rst = r;
    #1;
    ev = model_valid();
    er = (m_a.size() < 2) || (ev && rr);
    chk("in_ready_a", bus_a.in_ready, er);
    chk("in_ready_b", bus_b.in_ready, er);
    hs  = ev && rr;
    acc = v && er;
    @(posedge clk);
    if (r) begin
      m_a.delete(); m_k.delete(); m_age.delete();
      m_tot = 0; m_bit = 0; m_log = 0; m_fev = 1'b0;
      m_after_rst = 1'b1;
    end else begin
      if (clr) begin
        m_tot = 0; m_bit = 0; m_log = 0; m_fev = 1'b0;
      end else if (hs) begin
        m_tot++;
        if (m_k[0][0]) m_bit++;
        if (m_k[0][1]) m_log++;
        if (!m_fev && m_k[0] != 2'b00) begin
          m_fev = 1'b1; m_fa = m_a[0]; m_fk = m_k[0];
        end
      end
      if (hs) begin
        void'(m_a.pop_front()); void'(m_k.pop_front()); void'(m_age.pop_front());
      end
      foreach (m_age[i]) m_age[i]++;
      if (acc) begin
        k[0] = (b !== ~a);
        k[1] = (c !== ((a == 32'h0) ? 32'h1 : 32'h0));
        m_a.push_back(a); m_k.push_back(k); m_age.push_back(0);
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] a, b, c;
    int sel;
    m_tot = 0; m_bit = 0; m_log = 0; m_fev = 1'b0; m_fa = 32'h0; m_fk = 2'b00;
    m_after_rst = 1'b0;
    bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
    bus_a.res_ready = 1'b1; bus_b.res_ready = 1'b1;
    bus_a.in_a = 32'h0; bus_a.in_b = 32'h0; bus_a.in_c = 32'h0;
    bus_b.in_a = 32'h0; bus_b.in_b = 32'h0; bus_b.in_c = 32'h0;
    clear = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_after_rst = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    // Directed cases from the plan.
    cycle(1'b1, 32'h0, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0);
    idle(3);
    cycle(1'b1, 32'h5, 32'hFFFF_FFFA, 32'h1, 1'b1, 1'b0, 1'b0);
    idle(3);
    cycle(1'b1, 32'h0, 32'h0, 32'h3, 1'b1, 1'b0, 1'b0);
    idle(3);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a = 32'h1 + 32'(i) * 32'h0101_0007;
      cycle(1'b1, a, ~a, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    idle(3);
    for (int i = 0; i < 5; i++) begin
      a = 32'h100 + 32'(i);
      cycle(1'b1, a, (i == 1) ? a : ~a, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    idle(4);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h9, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    idle(2);
    // Randomized traffic with backpressure, clears and occasional mid-stream reset.
    for (int n = 0; n < 800; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: a = 32'h0;
        2: a = 32'h1 << $urandom_range(0, 31);
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) != 0) ? ~a : (~a ^ (32'h1 << $urandom_range(0, 31)));
      c = (a == 32'h0) ? 32'h1 : 32'h0;
      sel = $urandom_range(0, 5);
      if (sel == 4) c = c ^ 32'h1;
      else if (sel == 5) c = c | (32'h1 << $urandom_range(1, 31));
      cycle($urandom_range(0, 9) < 7, a, b, c, $urandom_range(0, 3) != 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end
    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/negation_checker.md
# negation_checker

Streaming self-checker for the negation operators. It accepts transactions carrying an operand `a`, a claimed bitwise negation `b` and a claimed logical negation `c`, and recomputes both. It reports a per-transaction verdict on a handshaked result stream and keeps saturating pass/fail statistics with sticky first-failure capture. It is the consuming, checking end of the negation stimulus path and sits between any negation producer and the regression reporting logic.

## Interface
- `W`, 32, operand width; matches Verilog `integer`.
- `CW`, 16, width of every statistics counter.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  transaction present.
- `in_ready`  out  1  checker can accept a transaction.
- `in_a`  in  W  operand.
- `in_b`  in  W  claimed `~a`.
- `in_c`  in  W  claimed `!a`, zero-extended to W.
- `res_valid`  out  1  verdict present.
- `res_ready`  in  1  downstream accepts the verdict.
- `res_ok`  out  1  both claims correct.
- `res_kind`  out  2  bit0 = bitwise mismatch, bit1 = logical mismatch.
- `clear`  in  1  zero statistics and re-arm sticky capture.
- `cnt_total`, `cnt_bit_err`, `cnt_log_err`  out  CW each  verdicts accepted, bitwise failures, logical failures.
- `first_err_valid`  out  1  sticky: a failing verdict has been accepted.
- `first_err_a`  out  W  operand of the first failing verdict.
- `first_err_kind`  out  2  `res_kind` of the first failing verdict.

## Operation
- Expected values: `exp_b = ~a` over all W bits. `exp_c = {W-1 zeros, (a == 0)}`; any nonzero upper bit in `in_c` is a logical mismatch.
- Stage 1 (S1) registers `a`, `in_b` vs `exp_b` XOR-reduced to a mismatch bit, and `in_c` vs `exp_c` compare bit.
- Stage 2 (S2) holds the verdict that drives `res_*`.
- Pipeline flow control:
  - S2 advances when `!s2_v || res_ready`.
  - S1 advances when `!s1_v || s2_advance`.
  - `in_ready = !s1_v || s2_advance`. Combinational from `res_ready`; no combinational path from `in_valid`.
- Statistics update only on a result handshake (`res_valid && res_ready`):
  - `cnt_total` increments.
  - `cnt_bit_err` increments if `res_kind[0]`.
  - `cnt_log_err` increments if `res_kind[1]`.
  - All counters saturate at 2^CW-1 and never wrap.
- First-failure capture: on the first handshake with `!res_ok` while `first_err_valid == 0`, latch `a` and kind, then set `first_err_valid`. Later failures do not overwrite.
- `clear` zeroes the three counters and the `first_err_*` registers. It does not flush the pipeline.
- `clear` has priority over a handshake in the same cycle; that verdict is not counted or captured.
- Reset clears everything: `s1_v`, `s2_v`, `res_valid`, `res_ok`, `res_kind`, all counters, `first_err_valid`, `first_err_a` and `first_err_kind` all go to 0.
- `in_ready` is 1 in the first cycle after reset.
- Reset asserted mid-stream drops every in-flight transaction without reporting it.

## Timing
- Latency is 2 cycles. A transaction accepted at edge N gives `res_valid` after edge N+1, for handshake at edge N+2 if `res_ready`.
- Throughput is 1 transaction per cycle while `res_ready` stays high.
- `res_*` are held stable while `res_valid && !res_ready`.
- At most 2 transactions are in flight. With `res_ready` low, the second accept fills S1 and `in_ready` then drops.
- Counters and sticky outputs change the cycle after the handshake edge.
- `clear` takes effect on the next edge.

## Structure
- Package `negation_pkg` holds:
  - the `res_kind` bit positions: `KIND_BIT = 0`, `KIND_LOG = 1`;
  - a typedef for the 2-bit kind;
  - function `logical_neg(a)`, returning the W-bit `exp_c`.
- One natural sub-module, `sat_counter`, instanced three times. Ports: clk, rst, clr, inc, count; parameter CW.

## Test plan
- `a = 0`, `b = 32'hFFFF_FFFF`, `c = 1` -> `res_ok = 1`, `res_kind = 0`, `cnt_total = 1`.
- `a = 32'h5`, `b = 32'hFFFF_FFFA`, `c = 1` (c should be 0) -> `res_kind = 2'b10`, `first_err_a = 5`, `cnt_log_err = 1`.
- `a = 32'h0`, `b = 32'h0`, `c = 32'h3` -> `res_kind = 2'b11`; both error counters increment.
- 8 back-to-back passing transactions with `res_ready` tied high -> 8 consecutive verdict cycles, `in_ready` constant 1, `cnt_total = 8`.
- `res_ready` low for 5 cycles while `in_valid` stays high -> exactly 2 accepts; `in_ready = 0` afterwards; verdicts stay held and are released in order.
- `clear` asserted in the same cycle as a failing handshake -> counters read 0 and `first_err_valid` is 0.
- With `CW = 2`, 5 passing verdicts -> `cnt_total = 3` (saturated).
